// File: rtl/mips_pkg.sv
// Shared MIPS-I encodings for the execute stage: opcodes, SPECIAL functs and REGIMM rt codes.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_SLTI    = 6'd10;
    localparam logic [5:0] OP_SLTIU   = 6'd11;
    localparam logic [5:0] OP_ANDI    = 6'd12;
    localparam logic [5:0] OP_ORI     = 6'd13;
    localparam logic [5:0] OP_XORI    = 6'd14;
    localparam logic [5:0] OP_LUI     = 6'd15;
    localparam logic [5:0] OP_LB      = 6'd32;
    localparam logic [5:0] OP_LH      = 6'd33;
    localparam logic [5:0] OP_LWL     = 6'd34;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_LBU     = 6'd36;
    localparam logic [5:0] OP_LHU     = 6'd37;
    localparam logic [5:0] OP_LWR     = 6'd38;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_SLLV  = 6'd4;
    localparam logic [5:0] F_SRLV  = 6'd6;
    localparam logic [5:0] F_SRAV  = 6'd7;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADDU  = 6'd33;
    localparam logic [5:0] F_SUBU  = 6'd35;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;
    localparam logic [4:0] RT_BLTZAL = 5'd16;
    localparam logic [4:0] RT_BGEZAL = 5'd17;

endpackage

// File: rtl/mips_exec_unit_if.sv
// Operand/result bundle between the core sequencer (master) and the execute stage (slave).
interface mips_exec_unit_if;
    logic        hl_write;
    logic [31:0] instr_word;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mem_rdata;
    logic [31:0] result;
    logic [31:0] eff_addr;
    logic        b_flag;
    logic [31:0] load_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output hl_write, instr_word, op1, op2, mem_rdata,
        input  result, eff_addr, b_flag, load_data, hi_out, lo_out
    );

    modport slave (
        input  hl_write, instr_word, op1, op2, mem_rdata,
        output result, eff_addr, b_flag, load_data, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_reg.sv
// 32-bit register with synchronous active-high reset and write enable; one each for HI and LO.
module hilo_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] q
);
    logic [31:0] data_d;
    logic [31:0] data_q;

    always_comb begin
        data_d = data_q;
        if (reset) begin
            data_d = 32'd0;
        end else if (we) begin
            data_d = wd;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/mips_exec_unit.sv
// MIPS-I execute stage: combinational ALU, branch compare, effective address, load alignment, HI/LO pair.
module mips_exec_unit
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mips_exec_unit_if.slave bus
);
    logic [31:0] instr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mem;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] simm;
    logic [31:0] zimm;

    logic [31:0] result;
    logic [31:0] eff_addr;
    logic        b_flag;
    logic [31:0] load_data;

    assign instr  = bus.instr_word;
    assign op1    = bus.op1;
    assign op2    = bus.op2;
    assign mem    = bus.mem_rdata;
    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign zimm   = {16'd0, instr[15:0]};

    // rs and rd select registers outside this block; the operands arrive already read
    logic unused_fields;
    assign unused_fields = ^{instr[25:21]};

    assign eff_addr = op1 + simm;

    always_comb begin
        result = 32'd0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                F_SLL:  result = op2 << shamt;
                F_SRL:  result = op2 >> shamt;
                F_SRA:  result = $unsigned($signed(op2) >>> shamt);
                F_SLLV: result = op2 << op1[4:0];
                F_SRLV: result = op2 >> op1[4:0];
                F_SRAV: result = $unsigned($signed(op2) >>> op1[4:0]);
                F_ADDU: result = op1 + op2;
                F_SUBU: result = op1 - op2;
                F_AND:  result = op1 & op2;
                F_OR:   result = op1 | op2;
                F_XOR:  result = op1 ^ op2;
                F_NOR:  result = ~(op1 | op2);
                F_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
                F_SLTU: result = {31'd0, op1 < op2};
                default: result = 32'd0;
            endcase
        end else begin
            case (opcode)
                OP_ADDIU: result = op1 + simm;
                OP_SLTI:  result = {31'd0, $signed(op1) < $signed(simm)};
                OP_SLTIU: result = {31'd0, op1 < simm};
                OP_ANDI:  result = op1 & zimm;
                OP_ORI:   result = op1 | zimm;
                OP_XORI:  result = op1 ^ zimm;
                OP_LUI:   result = {instr[15:0], 16'd0};
                default:  result = 32'd0;
            endcase
        end
    end

    always_comb begin
        b_flag = 1'b0;
        case (opcode)
            OP_BEQ:  b_flag = (op1 == op2);
            OP_BNE:  b_flag = (op1 != op2);
            OP_BLEZ: b_flag = op1[31] || (op1 == 32'd0);
            OP_BGTZ: b_flag = !op1[31] && (op1 != 32'd0);
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BLTZAL) begin
                    b_flag = op1[31];
                end else if (rt == RT_BGEZ || rt == RT_BGEZAL) begin
                    b_flag = !op1[31];
                end
            end
            default: b_flag = 1'b0;
        endcase
    end

    logic [1:0]  lane;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane      = eff_addr[1:0];
    assign lane_half = eff_addr[1] ? mem[31:16] : mem[15:0];

    always_comb begin
        lane_byte = mem[7:0];
        case (lane)
            2'd0: lane_byte = mem[7:0];
            2'd1: lane_byte = mem[15:8];
            2'd2: lane_byte = mem[23:16];
            2'd3: lane_byte = mem[31:24];
            default: lane_byte = mem[7:0];
        endcase
    end

    always_comb begin
        load_data = 32'd0;
        case (opcode)
            OP_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU: load_data = {24'd0, lane_byte};
            OP_LH:  load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU: load_data = {16'd0, lane_half};
            OP_LW:  load_data = mem;
            OP_LWL: begin
                case (lane)
                    2'd0: load_data = {mem[7:0],  op2[23:0]};
                    2'd1: load_data = {mem[15:0], op2[15:0]};
                    2'd2: load_data = {mem[23:0], op2[7:0]};
                    default: load_data = mem;
                endcase
            end
            OP_LWR: begin
                case (lane)
                    2'd0: load_data = mem;
                    2'd1: load_data = {op2[31:24], mem[31:8]};
                    2'd2: load_data = {op2[31:16], mem[31:16]};
                    default: load_data = {op2[31:8], mem[31:24]};
                endcase
            end
            default: load_data = 32'd0;
        endcase
    end

    // Signed divide runs on magnitudes so INT_MIN/-1 wraps instead of trapping in simulation
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] divu_b;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign prod_s = {{32{op1[31]}}, op1} * {{32{op2[31]}}, op2};
    assign prod_u = {32'd0, op1} * {32'd0, op2};
    assign a_mag  = op1[31] ? (32'd0 - op1) : op1;
    assign b_mag  = (op2 == 32'd0) ? 32'd1 : (op2[31] ? (32'd0 - op2) : op2);
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign q_s    = (op1[31] ^ op2[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s    = op1[31] ? (32'd0 - r_mag) : r_mag;
    assign divu_b = (op2 == 32'd0) ? 32'd1 : op2;
    assign q_u    = op1 / divu_b;
    assign r_u    = op1 % divu_b;

    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_wd = 32'd0;
        lo_wd = 32'd0;
        if (bus.hl_write && opcode == OP_SPECIAL) begin
            case (funct)
                F_MULT: begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    {hi_wd, lo_wd} = prod_s;
                end
                F_MULTU: begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    {hi_wd, lo_wd} = prod_u;
                end
                F_DIV: begin
                    hi_we = (op2 != 32'd0);
                    lo_we = (op2 != 32'd0);
                    hi_wd = r_s;
                    lo_wd = q_s;
                end
                F_DIVU: begin
                    hi_we = (op2 != 32'd0);
                    lo_we = (op2 != 32'd0);
                    hi_wd = r_u;
                    lo_wd = q_u;
                end
                F_MTHI: begin
                    hi_we = 1'b1;
                    hi_wd = op1;
                end
                F_MTLO: begin
                    lo_we = 1'b1;
                    lo_wd = op1;
                end
                default: begin
                    hi_we = 1'b0;
                    lo_we = 1'b0;
                end
            endcase
        end
    end

    hilo_reg u_hi (
        .clk   (clk),
        .reset (reset),
        .we    (hi_we),
        .wd    (hi_wd),
        .q     (hi_q)
    );

    hilo_reg u_lo (
        .clk   (clk),
        .reset (reset),
        .we    (lo_we),
        .wd    (lo_wd),
        .q     (lo_q)
    );

    assign bus.result    = result;
    assign bus.eff_addr  = eff_addr;
    assign bus.b_flag    = b_flag;
    assign bus.load_data = load_data;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: directed literal checks plus random stimulus against an arithmetic model.
module tb_mips_exec_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    bit   hl_known = 1'b0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mips_exec_unit_if bus ();

    mips_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t instr=%08h op1=%08h op2=%08h)",
                     name, act, exp, $time, bus.instr_word, bus.op1, bus.op2);
        end
    endtask

    function automatic logic [31:0] sext16(input logic [31:0] iw);
        return {{16{iw[15]}}, iw[15:0]};
    endfunction

    function automatic logic [31:0] m_result(input logic [31:0] iw, input logic [31:0] a, input logic [31:0] b);
        int op = int'(iw[31:26]);
        int fn = int'(iw[5:0]);
        int sh = int'(iw[10:6]);
        int sa = int'(a[4:0]);
        int sb = $signed(b);
        int sa32 = $signed(a);
        int si = $signed(sext16(iw));
        logic [31:0] zi = {16'd0, iw[15:0]};
        if (op == 0) begin
            case (fn)
                0:  return b << sh;
                2:  return b >> sh;
                3:  return 32'(sb >>> sh);
                4:  return b << sa;
                6:  return b >> sa;
                7:  return 32'(sb >>> sa);
                33: return a + b;
                35: return a - b;
                36: return a & b;
                37: return a | b;
                38: return a ^ b;
                39: return ~(a | b);
                42: return (sa32 < sb) ? 32'd1 : 32'd0;
                43: return (a < b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        case (op)
            9:  return a + sext16(iw);
            10: return (sa32 < si) ? 32'd1 : 32'd0;
            11: return (a < sext16(iw)) ? 32'd1 : 32'd0;
            12: return a & zi;
            13: return a | zi;
            14: return a ^ zi;
            15: return zi << 16;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_bflag(input logic [31:0] iw, input logic [31:0] a, input logic [31:0] b);
        int op = int'(iw[31:26]);
        int rt = int'(iw[20:16]);
        int sa = $signed(a);
        case (op)
            1: begin
                if (rt == 0 || rt == 16) return sa < 0;
                if (rt == 1 || rt == 17) return sa >= 0;
                return 1'b0;
            end
            4: return a == b;
            5: return a != b;
            6: return sa <= 0;
            7: return sa > 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] iw, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] m);
        logic [31:0] ea = a + sext16(iw);
        int lane = int'(ea[1:0]);
        logic [7:0] by = 8'(m >> (8 * lane));
        logic [15:0] hw = ea[1] ? m[31:16] : m[15:0];
        logic [63:0] lmask = (64'd1 << (8 * (3 - lane))) - 64'd1;
        case (int'(iw[31:26]))
            32: return 32'($signed(by));
            36: return {24'd0, by};
            33: return 32'($signed(hw));
            37: return {16'd0, hw};
            35: return m;
            34: return (m << (8 * (3 - lane))) | (b & lmask[31:0]);
            38: return (m >> (8 * lane)) | (b & ~(32'hFFFF_FFFF >> (8 * lane)));
            default: return 32'd0;
        endcase
    endfunction

    // Apply the architectural HI/LO effect of whatever was presented during the cycle ending now
    task automatic commit_model();
        logic [31:0] a = bus.op1;
        logic [31:0] b = bus.op2;
        longint sp;
        logic [63:0] up;
        longint q;
        longint r;
        if (reset === 1'b1) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            hl_known = 1'b1;
        end else if (bus.hl_write === 1'b1 && bus.instr_word[31:26] == 6'd0) begin
            case (int'(bus.instr_word[5:0]))
                24: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    m_hi = sp[63:32];
                    m_lo = sp[31:0];
                end
                25: begin
                    up = 64'(a) * 64'(b);
                    m_hi = up[63:32];
                    m_lo = up[31:0];
                end
                26: if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                27: if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                17: m_hi = a;
                19: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic apply(input logic [31:0] iw, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m, input logic hw, input logic rst);
        @(posedge clk);
        commit_model();
        #1;
        bus.instr_word = iw;
        bus.op1 = a;
        bus.op2 = b;
        bus.mem_rdata = m;
        bus.hl_write = hw;
        reset = rst;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 5'd3, 5'd4, 5'd5, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd2, rt, imm};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("result", bus.result, m_result(bus.instr_word, bus.op1, bus.op2));
            check("eff_addr", bus.eff_addr, bus.op1 + sext16(bus.instr_word));
            check("b_flag", {31'd0, bus.b_flag},
                  {31'd0, m_bflag(bus.instr_word, bus.op1, bus.op2)});
            check("load_data", bus.load_data,
                  m_load(bus.instr_word, bus.op1, bus.op2, bus.mem_rdata));
            if (hl_known) begin
                check("hi_out", bus.hi_out, m_hi);
                check("lo_out", bus.lo_out, m_lo);
            end
        end
    end

    localparam logic [31:0] NOP = 32'd0;
    localparam logic [31:0] MEMW = 32'h8877_6655;

    initial begin
        logic [31:0] iw;
        logic [5:0]  fns [12] = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd17, 6'd19,
                                  6'd0, 6'd3, 6'd7, 6'd42, 6'd43, 6'd35};
        reset = 1'b1;
        bus.instr_word = NOP;
        bus.op1 = 32'd0;
        bus.op2 = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.hl_write = 1'b0;

        apply(NOP, 0, 0, 0, 1'b0, 1'b1);
        chk_en = 1'b1;
        apply(NOP, 0, 0, 0, 1'b0, 1'b0);
        #2 check("reset_hi", bus.hi_out, 32'd0);
        check("reset_lo", bus.lo_out, 32'd0);

        apply(rtype(6'd33, 5'd0), 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b0);
        #2 check("addu_wrap", bus.result, 32'd1);
        apply(rtype(6'd42, 5'd0), 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0);
        #2 check("slt", bus.result, 32'd1);
        apply(rtype(6'd43, 5'd0), 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0);
        #2 check("sltu", bus.result, 32'd0);
        apply(rtype(6'd3, 5'd4), 32'd0, 32'h8000_0000, 0, 1'b0, 1'b0);
        #2 check("sra", bus.result, 32'hF800_0000);
        apply(itype(6'd15, 5'd0, 16'h1234), 32'd0, 32'd0, 0, 1'b0, 1'b0);
        #2 check("lui", bus.result, 32'h1234_0000);
        apply(itype(6'd13, 5'd0, 16'h8001), 32'hF0, 32'd0, 0, 1'b0, 1'b0);
        #2 check("ori", bus.result, 32'h80F1);
        apply(itype(6'd9, 5'd0, 16'hFFFF), 32'h10, 32'd0, 0, 1'b0, 1'b0);
        #2 check("addiu", bus.result, 32'hF);

        apply(rtype(6'd24, 5'd0), 32'hFFFF_FFFE, 32'd3, 0, 1'b1, 1'b0);
        apply(rtype(6'd26, 5'd0), 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 1'b0);
        #2 check("mult_hi", bus.hi_out, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo_out, 32'hFFFF_FFFA);
        apply(rtype(6'd26, 5'd0), 32'd55, 32'd0, 0, 1'b1, 1'b0);
        #2 check("div_lo", bus.lo_out, 32'hFFFF_FFFD);
        check("div_hi", bus.hi_out, 32'hFFFF_FFFF);
        apply(rtype(6'd17, 5'd0), 32'hAA, 32'd0, 0, 1'b1, 1'b0);
        #2 check("div0_hi", bus.hi_out, 32'hFFFF_FFFF);
        check("div0_lo", bus.lo_out, 32'hFFFF_FFFD);
        apply(rtype(6'd24, 5'd0), 32'd7, 32'd9, 0, 1'b0, 1'b0);
        #2 check("mthi_hi", bus.hi_out, 32'hAA);
        check("mthi_lo", bus.lo_out, 32'hFFFF_FFFD);
        apply(rtype(6'd17, 5'd0), 32'h55, 32'd0, 0, 1'b1, 1'b1);
        #2 check("nowrite_hi", bus.hi_out, 32'hAA);
        check("nowrite_lo", bus.lo_out, 32'hFFFF_FFFD);
        apply(NOP, 0, 0, 0, 1'b0, 1'b0);
        #2 check("reset_prio_hi", bus.hi_out, 32'd0);
        check("reset_prio_lo", bus.lo_out, 32'd0);

        apply(itype(6'd4, 5'd0, 16'd0), 32'd0, 32'd0, 0, 1'b0, 1'b0);
        #2 check("beq", {31'd0, bus.b_flag}, 32'd1);
        apply(itype(6'd7, 5'd0, 16'd0), 32'd0, 32'd5, 0, 1'b0, 1'b0);
        #2 check("bgtz", {31'd0, bus.b_flag}, 32'd0);
        apply(itype(6'd6, 5'd0, 16'd0), 32'd0, 32'd5, 0, 1'b0, 1'b0);
        #2 check("blez", {31'd0, bus.b_flag}, 32'd1);
        apply(itype(6'd1, 5'd16, 16'd0), 32'd0, 32'd5, 0, 1'b0, 1'b0);
        #2 check("bltzal", {31'd0, bus.b_flag}, 32'd0);
        apply(itype(6'd1, 5'd17, 16'd0), 32'd0, 32'd5, 0, 1'b0, 1'b0);
        #2 check("bgezal", {31'd0, bus.b_flag}, 32'd1);

        apply(itype(6'd32, 5'd0, 16'd3), 32'h1000, 32'd0, MEMW, 1'b0, 1'b0);
        #2 check("lb", bus.load_data, 32'hFFFF_FF88);
        apply(itype(6'd36, 5'd0, 16'd3), 32'h1000, 32'd0, MEMW, 1'b0, 1'b0);
        #2 check("lbu", bus.load_data, 32'h88);
        apply(itype(6'd33, 5'd0, 16'd2), 32'h1000, 32'd0, MEMW, 1'b0, 1'b0);
        #2 check("lh", bus.load_data, 32'hFFFF_8877);
        apply(itype(6'd34, 5'd0, 16'd1), 32'h1000, 32'hAABB_CCDD, MEMW, 1'b0, 1'b0);
        #2 check("lwl", bus.load_data, 32'h6655_CCDD);
        check("eff_addr_lit", bus.eff_addr, 32'h1001);
        apply(itype(6'd38, 5'd0, 16'd1), 32'h1000, 32'hAABB_CCDD, MEMW, 1'b0, 1'b0);
        #2 check("lwr", bus.load_data, 32'hAA88_7766);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1: iw = rtype(fns[$urandom_range(0, 11)], 5'($urandom));
                2, 3: iw = rtype(6'($urandom), 5'($urandom));
                4: iw = itype(6'd1, ($urandom_range(0, 4) == 0) ? 5'($urandom)
                              : 5'({$urandom_range(0, 1), 3'd0, 1'($urandom)}), 16'($urandom));
                5: iw = itype(6'($urandom_range(4, 7)), 5'($urandom), 16'($urandom));
                6, 7: iw = itype(6'($urandom_range(9, 15)), 5'($urandom), 16'($urandom));
                8: iw = itype(6'($urandom_range(32, 38)), 5'($urandom), 16'($urandom));
                default: iw = $urandom;
            endcase
            apply(iw, rnd_op(), rnd_op(), $urandom, 1'($urandom), $urandom_range(0, 63) == 0);
        end
        apply(NOP, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
